// File: rtl/alu_pkg.sv
// alu_pkg: types and helpers shared by the ALU, its result buffer and checkers.
//   opcode_e    - ALU operation encoding
//   flags_t     - result status flags {zero, carry, overflow, negative}
//   is_logic_op - operations that never produce a carry
//   is_arith_op - operations that may legally produce a signed overflow
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_CMP = 3'd7
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

  // Bitwise, shift and compare operations: the carry flag is meaningless for
  // these, so a set carry indicates a flag-generation fault.
  function automatic logic is_logic_op(opcode_e op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_CMP: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Adder-based operations: the only ones that can signal signed overflow.
  function automatic logic is_arith_op(opcode_e op);
    case (op)
      OP_ADD, OP_SUB: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: upstream (in_*) and downstream (out_*) valid/ready
// channels of the ALU result buffer.
//   master - the environment: drives in_* payload and out_ready
//   slave  - the buffer: drives in_ready and out_* payload
interface alu_result_buffer_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  flags_t           in_flags;
  opcode_e          in_opcode;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  flags_t           out_flags;
  opcode_e          out_opcode;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_result, in_flags, in_opcode, in_signed, in_tag,
    input  in_ready,
    input  out_valid, out_result, out_flags, out_opcode, out_tag,
    output out_ready
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_opcode, in_signed, in_tag,
    output in_ready,
    output out_valid, out_result, out_flags, out_opcode, out_tag,
    input  out_ready
  );

endinterface

// File: rtl/alu_result_chk.sv
// alu_result_chk: combinational consistency check of an ALU flag set against
// the result and operation that produced it.
//   result    - ALU result
//   flags     - flags reported with the result
//   opcode    - producing operation
//   signed_op - operation was signed
//   chk_fail  - 1 when the flags cannot belong to this result/operation
module alu_result_chk
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  flags_t           flags,
  input  opcode_e          opcode,
  input  logic             signed_op,
  output logic             chk_fail
);

  logic zero_bad;
  logic neg_bad;
  logic carry_bad;
  logic ovf_bad;
  logic cmp_bad;

  assign zero_bad  = flags.zero != (result == '0);
  assign neg_bad   = flags.negative != result[WIDTH-1];
  assign carry_bad = flags.carry && is_logic_op(opcode);
  assign ovf_bad   = flags.overflow && (!signed_op || !is_arith_op(opcode));
  // A compare yields a boolean, so anything above 1 is malformed.
  assign cmp_bad   = (opcode == OP_CMP) && (result > WIDTH'(1));

  assign chk_fail = zero_bad | neg_bad | carry_bad | ovf_bad | cmp_bad;

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: DEPTH-entry FIFO between the ALU and writeback, with
// sticky flag accumulation and a sticky flag-consistency error.
//   clk, rst     - clock, synchronous active-high reset
//   bus          - in_* push channel and out_* pop channel (slave side)
//   sticky_clr   - clears sticky_flags and flag_err (a same-cycle push is kept)
//   count        - current occupancy
//   sticky_flags - OR of the flags of all pushes since the last clear
//   flag_err     - some push since the last clear failed the consistency check
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_result_buffer_if.slave           bus,
  input  logic                         sticky_clr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output flags_t                       sticky_flags,
  output logic                         flag_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    opcode_e          opcode;
    flags_t           flags;
    logic [WIDTH-1:0] result;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             chk_fail;
  flags_t           sticky_nxt;

  // Ready depends only on registered occupancy: when full, a same-cycle pop
  // does not open a slot, which keeps out_ready off the in_ready path.
  assign bus.in_ready  = count < FULL_CNT;
  assign bus.out_valid = count != '0;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign head           = mem[rd_ptr];
  assign bus.out_result = head.result;
  assign bus.out_flags  = head.flags;
  assign bus.out_opcode = head.opcode;
  assign bus.out_tag    = head.tag;

  alu_result_chk #(.WIDTH(WIDTH)) u_chk (
    .result    (bus.in_result),
    .flags     (bus.in_flags),
    .opcode    (bus.in_opcode),
    .signed_op (bus.in_signed),
    .chk_fail  (chk_fail)
  );

  // NOTE: storage has no reset; validity is carried entirely by count and
  // the pointers, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{tag: bus.in_tag, opcode: bus.in_opcode,
                       flags: bus.in_flags, result: bus.in_result};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: defaulting every always_comb output first keeps it latch-free.
  always_comb begin
    sticky_nxt = sticky_clr ? '0 : sticky_flags;
    if (push) sticky_nxt = flags_t'(sticky_nxt | bus.in_flags);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
      flag_err     <= 1'b0;
    end else begin
      sticky_flags <= sticky_nxt;
      flag_err     <= (sticky_clr ? 1'b0 : flag_err) | (push && chk_fail);
    end
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the ALU datapath. Accepts one ALU result per cycle (result, flags, opcode, tag) over a valid/ready handshake and holds it in a DEPTH-entry FIFO until the writeback consumer takes it. Accumulates sticky status flags and checks each accepted flag set for internal consistency with its result and opcode, raising a sticky `flag_err`.

## Interface
- `WIDTH`, 32: result width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the transaction tag carried alongside each result.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. **Synchronous, active-high.**
- `in_valid` in 1: upstream presents a result.
- `in_ready` out 1: buffer can accept.
- `in_result` in WIDTH: ALU result.
- `in_flags` in `flags_t`: zero, carry, overflow, negative.
- `in_opcode` in `opcode_e`: operation that produced the result.
- `in_signed` in 1: signed_op qualifier of that operation.
- `in_tag` in TAG_W: transaction tag.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: consumer takes the head.
- `out_result`, `out_flags`, `out_opcode`, `out_tag` out: head entry fields.
- `count` out $clog2(DEPTH+1): current occupancy.
- `sticky_flags` out `flags_t`: OR of the flags of all pushes since the last clear.
- `flag_err` out 1: sticky consistency-check failure.
- `sticky_clr` in 1: clears `sticky_flags` and `flag_err`.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`. Push and pop may occur in the same cycle.
- `in_ready = (count < DEPTH)`. It is a function of registered state only, with no combinational path from `out_ready`. When the buffer is full, it does not accept a push even if a pop occurs that cycle.
- Storage is a circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping naturally at DEPTH-1 → 0. `count` is tracked separately:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Outputs are driven from the head entry. `out_*` fields are don't-care when `out_valid` is 0, but must hold stable while `out_valid && !out_ready`.
- Sticky flags update per accepted push: `sticky_flags <= (sticky_clr ? 0 : sticky_flags) | in_flags`. A push arriving in the same cycle as a clear is therefore retained. With a clear and no push, the register goes to 0.
- The consistency check runs on each accepted push. `chk_fail` is set if any of the following hold:
  - `flags.zero != (in_result == 0)`.
  - `flags.negative != in_result[WIDTH-1]`.
  - `flags.carry` is set and the opcode is one of AND, OR, XOR, SLL, SRL, CMP.
  - `flags.overflow` is set and either `!in_signed` or the opcode is not ADD or SUB.
  - The opcode is CMP and `in_result > 1`.
- `flag_err <= (sticky_clr ? 0 : flag_err) | (push && chk_fail)`.
- A failing entry is still stored and forwarded unchanged. The block only reports failures; it does not correct them.

## Timing
- Reset values: `count`=0, `out_valid`=0, `in_ready`=1, `sticky_flags`=0, `flag_err`=0, both pointers 0. Stored data is not reset.
- Latency is 1 cycle. A push into an empty buffer at edge N gives `out_valid`=1 in the cycle after edge N. There is no combinational bypass from `in_*` to `out_*`.
- Throughput is 1 entry per cycle sustained at any occupancy below DEPTH.
- Reset mid-operation: all entries are discarded at the reset edge, and outputs take their reset values the following cycle. A push or pop in the reset cycle is ignored.
- Pop when empty is impossible because `out_valid`=0, and `out_ready` is ignored. Push when full is impossible because `in_ready`=0, and `in_valid` is ignored.

## Structure
- `opcode_e` and `flags_t` come from `alu_pkg`. Add `alu_pkg::is_logic_op(opcode_e)` and `alu_pkg::is_arith_op(opcode_e)` functions, shared with the ALU and its checkers.
- One sub-module: `alu_result_chk`, the combinational consistency check. Inputs are `result`, `flags`, `opcode`, and `signed_op`; the output is `chk_fail`. It is reusable by the scoreboard.
- FIFO storage is inline. Each entry is a packed struct `{tag, opcode, flags, result}` declared locally.

## Test plan
- **Reset and single pass:** after reset, push result=0x0000_0005 with ADD, flags=0, tag=3.
  - `out_valid` rises in the next cycle with those exact values.
  - `count` goes 0→1→0 after the pop.
  - `flag_err` stays 0.
- **Full and backpressure:** hold `out_ready`=0 and push 5 entries with tags 0–4.
  - `in_ready` drops after the 4th push, and the 5th is not accepted.
  - Release `out_ready`: tags pop in order 0,1,2,3.
- **Simultaneous push and pop at count=2, and pointer wrap:** stream 10 entries with both `in_valid` and `out_ready` held high.
  - `count` stays constant.
  - Output order matches input order across pointer wrap.
- **Consistency errors:**
  - Push XOR with result=0 and flags.zero=0 → `flag_err`=1.
  - Assert `sticky_clr` → `flag_err`=0.
  - Push unsigned ADD with overflow=1 → `flag_err`=1.
- **Sticky clear race:** after a carry push, sticky carry=1. In one cycle, assert `sticky_clr` and push flags.overflow=1 (signed SUB, valid).
  - Result next cycle: `sticky_flags`: carry=0, overflow=1.
- **Reset mid-stream:** with 3 entries held, assert `rst` for 1 cycle.
  - Next cycle: `count`=0, `out_valid`=0, `in_ready`=1, `sticky_flags`=0.
